// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite master: response codes, FSM state
// encoding and the addresses of the ctrl/mode register-file slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] CTRL_ADDR = 32'h0000_0000;
    localparam logic [31:0] MODE_ADDR = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/axi_lite_wdog.sv
// Watchdog for the AXI-Lite master: a down-counter reloaded with LIMIT-1 on
// clear, decremented while enabled, flagging expiry on its LIMIT-th enabled
// cycle after a clear.
module axi_lite_wdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] count;

    // Reload on clear, count down while enabled, saturate at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= CW'(LIMIT - 1);
        end else if (clear) begin
            count <= CW'(LIMIT - 1);
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: converts one local command into one AXI-Lite read or
// write and returns the captured response on a valid/ready port.
// Optional watchdog abort is enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                s_axi_aclk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    import axi_lite_pkg::*;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done, w_done;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                expired;
    logic                abort;

    // All channel valids/readies are decoded from registered state, so none
    // of them is combinational from a slave ready or from rsp_ready.
    assign cmd_ready     = (state == IDLE);
    assign rsp_valid     = (state == RSP);
    assign m_axi_awvalid = (state == WR) && !aw_done;
    assign m_axi_wvalid  = (state == WR) && !w_done;
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_rready  = (state == RD_DATA);

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid  && m_axi_wready;
    assign b_hs  = m_axi_bvalid  && m_axi_bready;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign r_hs  = m_axi_rvalid  && m_axi_rready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    logic busy;
    logic timeout_q;

    assign busy = (state == WR) || (state == WR_RESP) ||
                  (state == RD_ADDR) || (state == RD_DATA);

    // The counter restarts whenever the FSM changes state.
    axi_lite_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (s_axi_aclk),
        .reset   (reset),
        .clear   (state_next != state),
        .enable  (busy),
        .expired (expired)
    );

    // Timeout flag: cleared on a new command, set when the watchdog aborts.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if ((state == IDLE) && cmd_valid) begin
            timeout_q <= 1'b0;
        end else if (abort) begin
            timeout_q <= 1'b1;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    // Watchdog compiled out: TIMEOUT_CYCLES has no effect and nothing expires.
    assign expired     = (TIMEOUT_CYCLES < 0);
    assign rsp_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a completing handshake always wins over expiry.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = cmd_wr ? WR : RD_ADDR;
                end
            end
            WR: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = WR_RESP;
                end else if (expired) begin
                    state_next = RSP;
                    abort      = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_next = RSP;
                end else if (expired) begin
                    state_next = RSP;
                    abort      = 1'b1;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_next = RD_DATA;
                end else if (expired) begin
                    state_next = RSP;
                    abort      = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_next = RSP;
                end else if (expired) begin
                    state_next = RSP;
                    abort      = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command capture, per-channel completion flags and response capture.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (b_hs) begin
                        resp_q  <= m_axi_bresp;
                        rdata_q <= '0;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        resp_q  <= m_axi_rresp;
                        rdata_q <= m_axi_rdata;
                    end
                end
                default: ;
            endcase
            if (abort) begin
                resp_q  <= RESP_SLVERR;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Testbench for axi_lite_master: table-driven vectors, hand-written timing
// sequences and randomized traffic against a ctrl/mode register-file slave.
// The watchdog sequence runs when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]    m_axi_awprot, m_axi_arprot;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]    m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_lite_master #(
        .ADDR_W (AW), .DATA_W (DW), .TIMEOUT_CYCLES (TO)
    ) dut (
        .s_axi_aclk    (clk),           .reset         (reset),
        .cmd_valid     (cmd_valid),     .cmd_ready     (cmd_ready),
        .cmd_wr        (cmd_wr),        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),     .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),     .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),     .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (m_axi_awaddr),  .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),   .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),  .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),   .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),  .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid), .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),   .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),  .m_axi_rready  (m_axi_rready)
    );

    // ---------------- register-file slave (ctrl @0x0, mode @0x1) ----------------
    // aw_hi/w_hi/ar_hi: number of cycles the valid stays high before ready.
    // b_dly/r_dly: extra cycles before the response valid rises.
    int aw_hi = 1, w_hi = 1, ar_hi = 1, b_dly = 0, r_dly = 0;
    bit ar_stuck = 1'b0;

    logic [31:0] s_regs [2] = '{32'h0, 32'h0};
    logic        got_aw, got_w, got_ar;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;

    assign m_axi_awready = m_axi_awvalid && (aw_wait + 1 >= aw_hi);
    assign m_axi_wready  = m_axi_wvalid  && (w_wait + 1 >= w_hi);
    assign m_axi_arready = m_axi_arvalid && !ar_stuck && (ar_wait + 1 >= ar_hi);

    wire        aw_hs = m_axi_awvalid && m_axi_awready;
    wire        w_hs  = m_axi_wvalid && m_axi_wready;
    wire        ar_hs = m_axi_arvalid && m_axi_arready;
    wire [31:0] wr_addr = got_aw ? s_awaddr : m_axi_awaddr;
    wire [31:0] wr_data = got_w ? s_wdata : m_axi_wdata;
    wire [3:0]  wr_strb = got_w ? s_wstrb : m_axi_wstrb;
    wire [31:0] rd_addr = got_ar ? s_araddr : m_axi_araddr;
    wire        wr_go   = (got_aw || aw_hs) && (got_w || w_hs);
    wire        rd_go   = got_ar || ar_hs;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
            m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
        end else begin
            aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
            w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
            ar_wait <= (m_axi_arvalid && !m_axi_arready) ? ar_wait + 1 : 0;
            if (aw_hs) begin s_awaddr <= m_axi_awaddr; got_aw <= 1'b1; end
            if (w_hs)  begin s_wdata <= m_axi_wdata; s_wstrb <= m_axi_wstrb; got_w <= 1'b1; end
            if (ar_hs) begin s_araddr <= m_axi_araddr; got_ar <= 1'b1; end
            if (wr_go && !m_axi_bvalid) begin
                if (b_wait >= b_dly) begin
                    m_axi_bvalid <= 1'b1;
                    m_axi_bresp  <= (wr_addr < 2) ? 2'b00 : 2'b11;
                    if (wr_addr < 2) s_regs[wr_addr[0]] <= merge(s_regs[wr_addr[0]], wr_data, wr_strb);
                    got_aw <= 1'b0; got_w <= 1'b0; b_wait <= 0;
                end else begin
                    b_wait <= b_wait + 1;
                end
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (rd_go && !m_axi_rvalid) begin
                if (r_wait >= r_dly) begin
                    m_axi_rvalid <= 1'b1;
                    m_axi_rresp  <= (rd_addr < 2) ? 2'b00 : 2'b11;
                    m_axi_rdata  <= (rd_addr < 2) ? s_regs[rd_addr[0]] : 32'h0;
                    got_ar <= 1'b0; r_wait <= 0;
                end else begin
                    r_wait <= r_wait + 1;
                end
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a two-word register file; any other address decodes
    // to DECERR with zero read data. Writes merge byte lanes by strobe.
    logic [31:0] m_regs [2] = '{32'h0, 32'h0};

    task automatic model(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output logic [31:0] rdata, output logic [1:0] resp);
        rdata = 32'h0;
        resp  = 2'b00;
        if (addr > 32'h1) begin
            resp = 2'b11;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_regs[addr[0]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            rdata = m_regs[addr[0]];
        end
    endtask

    // Per-transaction observations gathered while waiting for the response.
    int awv_cnt, wv_cnt, arv_cnt;
    bit bready_early, addr_moved, hold_ok, done_ok;

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int hold,
                           output logic [31:0] rdata, output logic [1:0] resp,
                           output logic tmo, output int lat);
        int  guard;
        bit  rb, aw_seen;
        rdata = 32'hDEAD_DEAD; resp = 2'bxx; tmo = 1'bx; lat = 0;
        cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_valid = 1'b1;
        guard = 0;
        do begin
            rb = cmd_ready;
            @(posedge clk); #1;
            guard++;
        end while (!rb && guard < 100);
        cmd_valid = 1'b0;
        if (!rb) begin check("cmd_accept_wait", 0, 1); return; end
        lat = 1; awv_cnt = 0; wv_cnt = 0; arv_cnt = 0;
        bready_early = 0; addr_moved = 0; aw_seen = 0;
        while (!rsp_valid && lat < 200) begin
            if (m_axi_awvalid) awv_cnt++;
            if (m_axi_wvalid) wv_cnt++;
            if (m_axi_arvalid) arv_cnt++;
            if (m_axi_bready && !aw_seen) bready_early = 1;
            if (aw_hs) aw_seen = 1;
            if (m_axi_awvalid && m_axi_awaddr !== addr) addr_moved = 1;
            if (m_axi_arvalid && m_axi_araddr !== addr) addr_moved = 1;
            if (m_axi_wvalid && m_axi_wdata !== wdata) addr_moved = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin check("rsp_valid_wait", 0, 1); return; end
        rdata = rsp_rdata; resp = rsp_resp; tmo = rsp_timeout;
        hold_ok = 1;
        for (int i = 0; i < hold; i++) begin
            if (!(rsp_valid && rsp_rdata === rdata && rsp_resp === resp && !cmd_ready)) hold_ok = 0;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        done_ok = !rsp_valid && cmd_ready;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_hi, w_hi, ar_hi, b_dly, r_dly, hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] rd, m_rd;
        logic [1:0]  rs, m_rs;
        logic        tm;
        int          lat;
        bit          wr;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          sel;

        tbl[0] = '{1, 32'h0,  32'h0000_0003, 4'hF, 1, 1, 1, 0, 0, 0, 32'h0,         2'b00};
        tbl[1] = '{0, 32'h0,  32'h0,         4'h0, 1, 1, 1, 0, 0, 0, 32'h0000_0003, 2'b00};
        tbl[2] = '{1, 32'h1,  32'hA5A5_1234, 4'h3, 2, 1, 1, 1, 0, 0, 32'h0,         2'b00};
        tbl[3] = '{0, 32'h1,  32'h0,         4'h0, 1, 1, 2, 0, 1, 0, 32'h0000_1234, 2'b00};
        tbl[4] = '{1, 32'h1,  32'hDEAD_BEEF, 4'hC, 1, 3, 1, 2, 0, 1, 32'h0,         2'b00};
        tbl[5] = '{0, 32'h1,  32'h0,         4'h0, 1, 1, 3, 0, 2, 0, 32'hDEAD_1234, 2'b00};
        tbl[6] = '{0, 32'h10, 32'h0,         4'h0, 1, 1, 1, 0, 0, 0, 32'h0,         2'b11};
        tbl[7] = '{1, 32'h20, 32'h1111_2222, 4'hF, 2, 2, 1, 0, 0, 0, 32'h0,         2'b11};
        tbl[8] = '{0, 32'h0,  32'h0,         4'h0, 1, 1, 1, 0, 0, 2, 32'h0000_0003, 2'b00};

        reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        check("reset_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 0);
        check("reset_addr_data", {m_axi_awaddr, m_axi_wdata}, 0);
        check("prot_tied", {m_axi_awprot, m_axi_arprot}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            aw_hi = tbl[i].aw_hi; w_hi = tbl[i].w_hi; ar_hi = tbl[i].ar_hi;
            b_dly = tbl[i].b_dly; r_dly = tbl[i].r_dly;
            model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, m_rd, m_rs);
            run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].hold, rd, rs, tm, lat);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_resp", i), rs, tbl[i].exp_resp);
            check($sformatf("tbl%0d_timeout", i), tm, 0);
            check($sformatf("tbl%0d_stable", i), addr_moved, 0);
            if (tbl[i].aw_hi == 1 && tbl[i].w_hi == 1 && tbl[i].ar_hi == 1 &&
                tbl[i].b_dly == 0 && tbl[i].r_dly == 0)
                check($sformatf("tbl%0d_latency", i), lat, 3);
        end

        // awready delayed three cycles, wready immediate.
        aw_hi = 3; w_hi = 1; b_dly = 0; r_dly = 0; ar_hi = 1;
        model(1, 32'h1, 32'h0000_00AA, 4'h1, m_rd, m_rs);
        run_cmd(1, 32'h1, 32'h0000_00AA, 4'h1, 0, rd, rs, tm, lat);
        check("awdly_awvalid_cycles", awv_cnt, 3);
        check("awdly_wvalid_cycles", wv_cnt, 1);
        check("awdly_bready_early", bready_early, 0);
        check("awdly_resp", rs, 2'b00);
        aw_hi = 1;

        // Response held off for five cycles.
        model(0, 32'h1, 32'h0, 4'h0, m_rd, m_rs);
        run_cmd(0, 32'h1, 32'h0, 4'h0, 5, rd, rs, tm, lat);
        check("hold_rdata", rd, m_rd);
        check("hold_stable", hold_ok, 1);
        check("hold_release", done_ok, 1);

        // DECERR on read of an unmapped address.
        run_cmd(0, 32'h10, 32'h0, 4'h0, 0, rd, rs, tm, lat);
        check("decerr_resp", rs, 2'b11);
        check("decerr_timeout", tm, 0);

        // Reset while arvalid is high.
        ar_hi = 8;
        cmd_wr = 1'b0; cmd_addr = 32'h0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("midreset_arvalid_before", m_axi_arvalid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_arvalid_after", m_axi_arvalid, 0);
        check("midreset_cmd_ready", cmd_ready, 1);
        begin
            bit saw_rsp;
            saw_rsp = rsp_valid;
            for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rsp_valid) saw_rsp = 1; end
            check("midreset_no_rsp", saw_rsp, 0);
        end
        ar_hi = 1;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // arready never arrives: the watchdog aborts the read.
        ar_stuck = 1'b1;
        run_cmd(0, 32'h0, 32'h0, 4'h0, 0, rd, rs, tm, lat);
        check("wdog_arvalid_cycles", arv_cnt, TO);
        check("wdog_resp", rs, 2'b10);
        check("wdog_timeout", tm, 1);
        check("wdog_rdata", rd, 0);
        ar_stuck = 1'b0;
`endif

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            aw_hi = $urandom_range(1, 4); w_hi = $urandom_range(1, 4);
            ar_hi = $urandom_range(1, 4); b_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            a   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h1 : (sel == 2) ? 32'h10 : ($urandom | 32'h100);
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            model(wr, a, d, s, m_rd, m_rs);
            run_cmd(wr, a, d, s, $urandom_range(0, 3), rd, rs, tm, lat);
            check($sformatf("rnd%0d_rdata", n), rd, m_rd);
            check($sformatf("rnd%0d_resp", n), rs, m_rs);
            check($sformatf("rnd%0d_timeout", n), tm, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
